// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the word-addressed PC and walks
// each instruction through FETCH/DECODE/EXEC/MEM/WB, counting retirements.
module pc_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_in,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_mem,
    input  logic [PC_W-1:0]  target,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             mem_req,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_TGT
    } pc_sel_e;

    state_e          cur;
    state_e          nxt;
    pc_sel_e         pc_sel;
    logic            retire;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + PC_W'(1);
    assign state  = cur;

    // State register; reset wins over every other condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic; EXEC resolves jump > branch > mem > ALU.
    always_comb begin
        nxt = S_IDLE;
        unique case (cur)
            S_IDLE: begin
                nxt = start ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                nxt = S_DECODE;
            end
            S_DECODE: begin
                nxt = halt_in ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_jump || is_branch) begin
                    nxt = S_FETCH;
                end else if (is_mem) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                nxt = mem_ready ? S_WB : S_MEM;
            end
            S_WB: begin
                nxt = S_FETCH;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Moore strobes decoded straight from the current state.
    always_comb begin
        ir_load = 1'b0;
        mem_req = 1'b0;
        reg_we  = 1'b0;
        halted  = 1'b0;
        unique case (cur)
            S_FETCH: ir_load = 1'b1;
            S_MEM:   mem_req = 1'b1;
            S_WB:    reg_we  = 1'b1;
            S_HALT:  halted  = 1'b1;
            default: ;
        endcase
    end

    // PC source and retire event: only EXEC->FETCH and WB->FETCH move them.
    always_comb begin
        pc_sel = PC_HOLD;
        retire = 1'b0;
        unique case (cur)
            S_EXEC: begin
                if (is_jump) begin
                    pc_sel = PC_TGT;
                    retire = 1'b1;
                end else if (is_branch) begin
                    pc_sel = branch_taken ? PC_TGT : PC_SEQ;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                pc_sel = PC_SEQ;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // PC register; pc+1 wraps naturally at the word-address width.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            unique case (pc_sel)
                PC_SEQ:  pc <= pc_inc;
                PC_TGT:  pc <= target;
                default: pc <= pc;
            endcase
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire && !(&retired)) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against an instruction-level model of
// PC, retire count and per-kind cycle cost.
module tb_pc_sequencer;

    localparam int PW  = 10;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    localparam int K_ALU  = 0;
    localparam int K_JMP  = 1;
    localparam int K_BRT  = 2;
    localparam int K_BRN  = 3;
    localparam int K_MEM  = 4;
    localparam int K_HALT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt_in = 1'b0;
    logic          is_jump = 1'b0;
    logic          is_branch = 1'b0;
    logic          branch_taken = 1'b0;
    logic          is_mem = 1'b0;
    logic [PW-1:0] target = '0;
    logic          mem_ready = 1'b0;
    logic [PW-1:0] pc;
    logic          ir_load;
    logic          mem_req;
    logic          reg_we;
    logic [2:0]    state;
    logic          halted;
    logic [CW-1:0] retired;

    int n_chk = 0;
    int n_pass = 0;
    int mpc = 0;
    int mret = 0;

    pc_sequencer #(
        .PC_W(PW),
        .RESET_PC('0),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .halt_in(halt_in),
        .is_jump(is_jump),
        .is_branch(is_branch),
        .branch_taken(branch_taken),
        .is_mem(is_mem),
        .target(target),
        .mem_ready(mem_ready),
        .pc(pc),
        .ir_load(ir_load),
        .mem_req(mem_req),
        .reg_we(reg_we),
        .state(state),
        .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random values on every input the current state should ignore.
    task automatic noise();
        start        = 1'($urandom);
        halt_in      = 1'($urandom);
        is_jump      = 1'($urandom);
        is_branch    = 1'($urandom);
        branch_taken = 1'($urandom);
        is_mem       = 1'($urandom);
        mem_ready    = 1'($urandom);
        target       = PW'($urandom);
    endtask

    // Called with the DUT in FETCH; leaves it in the next FETCH (or HALT).
    task automatic run_instr(input int kind, input int tgt, input int nwait);
        int cyc;
        int exp_cyc;
        chk("fetch_state", state, 1);
        chk("fetch_ir_load", ir_load, 1);
        chk("fetch_reg_we", reg_we, 0);
        chk("fetch_pc", pc, mpc);
        chk("fetch_retired", retired, mret);
        noise();
        tick();
        cyc = 1;
        chk("decode_state", state, 2);
        chk("ir_load_pulse", ir_load, 0);
        noise();
        halt_in = (kind == K_HALT);
        tick();
        cyc++;
        if (kind == K_HALT) begin
            chk("halt_state", state, 6);
            chk("halted", halted, 1);
            chk("halt_pc", pc, mpc);
            return;
        end
        chk("exec_state", state, 3);
        noise();
        target = PW'(tgt);
        case (kind)
            K_JMP: begin
                is_jump = 1'b1; is_branch = 1'b1; is_mem = 1'b1;
            end
            K_BRT: begin
                is_jump = 1'b0; is_branch = 1'b1;
                branch_taken = 1'b1; is_mem = 1'b1;
            end
            K_BRN: begin
                is_jump = 1'b0; is_branch = 1'b1;
                branch_taken = 1'b0; is_mem = 1'b1;
            end
            K_MEM: begin
                is_jump = 1'b0; is_branch = 1'b0; is_mem = 1'b1;
            end
            default: begin
                is_jump = 1'b0; is_branch = 1'b0; is_mem = 1'b0;
            end
        endcase
        tick();
        cyc++;
        if (kind == K_MEM) begin
            for (int i = 0; i <= nwait; i++) begin
                chk("mem_state", state, 4);
                chk("mem_req", mem_req, 1);
                noise();
                mem_ready = (i == nwait);
                tick();
                cyc++;
            end
        end
        if (kind == K_ALU || kind == K_MEM) begin
            chk("wb_state", state, 5);
            chk("wb_reg_we", reg_we, 1);
            chk("wb_pc_hold", pc, mpc);
            noise();
            tick();
            cyc++;
        end
        case (kind)
            K_JMP, K_BRT: begin mpc = tgt; exp_cyc = 3; end
            K_BRN:        begin mpc = (mpc + 1) % (1 << PW); exp_cyc = 3; end
            K_MEM:        begin mpc = (mpc + 1) % (1 << PW); exp_cyc = 5 + nwait; end
            default:      begin mpc = (mpc + 1) % (1 << PW); exp_cyc = 4; end
        endcase
        if (mret < MAX) mret++;
        chk("instr_cycles", cyc, exp_cyc);
    endtask

    task automatic do_reset_start();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {ir_load, mem_req, reg_we, halted}, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            noise();
            start = 1'b0;
            tick();
            chk("idle_hold", state, 0);
            chk("idle_pc", pc, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        mpc = 0;
        mret = 0;
    endtask

    initial begin
        do_reset_start();

        for (int i = 0; i < 3; i++) run_instr(K_ALU, 0, 0);
        chk("alu_retired", retired, 3);

        run_instr(K_JMP, 5, 0);
        run_instr(K_BRT, 'h040, 0);
        chk("br_taken_pc", pc, 'h040);
        run_instr(K_JMP, 5, 0);
        run_instr(K_BRN, 'h040, 0);
        chk("br_not_taken_pc", pc, 6);

        run_instr(K_MEM, 0, 3);
        run_instr(K_MEM, 0, 0);

        run_instr(K_JMP, 'h3FF, 0);
        run_instr(K_ALU, 0, 0);
        chk("pc_wrap", pc, 0);
        run_instr(K_JMP, 'h123, 0);
        chk("jump_priority_pc", pc, 'h123);

        for (int i = 0; i < 300; i++) begin
            run_instr(int'($urandom_range(0, 4)),
                      int'($urandom_range(0, (1 << PW) - 1)),
                      int'($urandom_range(0, 4)));
        end
        chk("retired_saturated", retired, MAX);

        run_instr(K_HALT, 0, 0);
        for (int i = 0; i < 10; i++) begin
            noise();
            start = 1'b1;
            tick();
            chk("halt_stay", state, 6);
            chk("halt_pc_frozen", pc, mpc);
            chk("halt_ret_frozen", retired, mret);
        end

        do_reset_start();
        run_instr(K_ALU, 0, 0);
        noise();
        tick();
        halt_in = 1'b0;
        tick();
        is_jump = 1'b0;
        is_branch = 1'b0;
        is_mem = 1'b1;
        tick();
        chk("pre_reset_mem", state, 4);
        mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("mem_reset_state", state, 0);
        chk("mem_reset_pc", pc, 0);
        chk("mem_reset_req", mem_req, 0);
        chk("mem_reset_ret", retired, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
